// File: rtl/dispatch_demux_if.sv
// Stream bundle for dispatch_demux: one steered input stream and two output streams.
interface dispatch_demux_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_sel;
  logic             out0_valid;
  logic             out0_ready;
  logic [WIDTH-1:0] out0_data;
  logic             out1_valid;
  logic             out1_ready;
  logic [WIDTH-1:0] out1_data;

  // Producer/consumer side: drives input item and output readys.
  modport master (
    output in_valid, in_data, in_sel, out0_ready, out1_ready,
    input  in_ready, out0_valid, out0_data, out1_valid, out1_data
  );

  // Demux side: accepts input item and presents both output slots.
  modport slave (
    input  in_valid, in_data, in_sel, out0_ready, out1_ready,
    output in_ready, out0_valid, out0_data, out1_valid, out1_data
  );
endinterface

// File: rtl/dispatch_demux.sv
// dispatch_demux: steers one valid/ready stream to issue slot 0 or 1 by in_sel,
// with per-slot registered storage, flush and 16-bit delivery counters.
// Build option DISPATCH_SKID_EN: 2-entry FIFO per slot (in_ready from registered
// state only); otherwise a 1-entry register per slot.
module dispatch_demux #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  dispatch_demux_if.slave     bus,
  output logic [15:0]         cnt0,
  output logic [15:0]         cnt1
);

  localparam int unsigned CW = 16;

  logic [1:0]            out_ready_c;
  logic [1:0]            valid_c;
  logic [1:0]            acc_c;
  logic [1:0]            dlv_c;
  logic [1:0][WIDTH-1:0] head_c;
  logic                  in_ready_c;
  logic [1:0][CW-1:0]    cnt_q;

  assign out_ready_c = {bus.out1_ready, bus.out0_ready};
  assign acc_c       = {bus.in_sel, ~bus.in_sel} & {2{bus.in_valid & in_ready_c}};
  assign dlv_c       = valid_c & out_ready_c;

`ifdef DISPATCH_SKID_EN
  logic [1:0][1:0]            count_q;
  logic [1:0]                 rd_q;
  logic [1:0]                 wr_q;
  logic [1:0][1:0][WIDTH-1:0] mem_q;

  // Room check looks only at registered occupancy, so consumer ready never reaches in_ready.
  assign in_ready_c = ~flush & (count_q[bus.in_sel] < 2'd2);

  // Present the oldest entry of each slot FIFO.
  always_comb begin
    valid_c = '0;
    head_c  = '0;
    for (int n = 0; n < 2; n++) begin
      valid_c[n] = (count_q[n] != 2'd0);
      head_c[n]  = mem_q[n][rd_q[n]];
    end
  end

  // Per-slot 2-entry FIFO; flush drops occupancy and realigns pointers.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      mem_q   <= '0;
    end else if (flush) begin
      count_q <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
    end else begin
      for (int n = 0; n < 2; n++) begin
        if (acc_c[n]) begin
          mem_q[n][wr_q[n]] <= bus.in_data;
          wr_q[n]           <= ~wr_q[n];
        end
        if (dlv_c[n]) begin
          rd_q[n] <= ~rd_q[n];
        end
        case ({acc_c[n], dlv_c[n]})
          2'b10:   count_q[n] <= count_q[n] + 2'd1;
          2'b01:   count_q[n] <= count_q[n] - 2'd1;
          default: count_q[n] <= count_q[n];
        endcase
      end
    end
  end
`else
  logic [1:0]            full_q;
  logic [1:0][WIDTH-1:0] data_q;

  // A full slot can still take a new item when its consumer drains it this cycle.
  assign in_ready_c = ~flush & (~full_q[bus.in_sel] | out_ready_c[bus.in_sel]);
  assign valid_c    = full_q;
  assign head_c     = data_q;

  // Per-slot holding register; accept wins over deliver so a same-cycle pair replaces.
  always_ff @(posedge clk) begin
    if (reset) begin
      full_q <= '0;
      data_q <= '0;
    end else if (flush) begin
      full_q <= '0;
    end else begin
      for (int n = 0; n < 2; n++) begin
        if (acc_c[n]) begin
          data_q[n] <= bus.in_data;
          full_q[n] <= 1'b1;
        end else if (dlv_c[n]) begin
          full_q[n] <= 1'b0;
        end
      end
    end
  end
`endif

  // Delivery counters ignore flush; a delivery in the flush cycle still counts.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      for (int n = 0; n < 2; n++) begin
        if (dlv_c[n]) begin
          cnt_q[n] <= cnt_q[n] + CW'(1);
        end
      end
    end
  end

  assign bus.in_ready   = in_ready_c;
  assign bus.out0_valid = valid_c[0];
  assign bus.out0_data  = head_c[0];
  assign bus.out1_valid = valid_c[1];
  assign bus.out1_data  = head_c[1];
  assign cnt0           = cnt_q[0];
  assign cnt1           = cnt_q[1];

endmodule

// File: tb/tb_dispatch_demux.sv
// Testbench for dispatch_demux: scenario tasks plus a scoreboard monitor that
// predicts in_ready, slot contents and counters from its own queue model.
module tb_dispatch_demux;

  localparam int unsigned WIDTH = 8;
`ifdef DISPATCH_SKID_EN
  localparam int unsigned DEPTH  = 2;
  localparam logic [15:0] CNT0_BP = 16'd5;
`else
  localparam int unsigned DEPTH  = 1;
  localparam logic [15:0] CNT0_BP = 16'd4;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic [15:0] cnt0;
  logic [15:0] cnt1;

  dispatch_demux_if #(.WIDTH(WIDTH)) bus ();

  dispatch_demux #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus),
    .cnt0  (cnt0),
    .cnt1  (cnt1)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [WIDTH-1:0] q0[$];
  logic [WIDTH-1:0] q1[$];
  logic [15:0]      exp_cnt0;
  logic [15:0]      exp_cnt1;
  logic             room0;
  logic             room1;
  logic             exp_ir;

  // Scoreboard: at negedge the inputs for the coming edge are stable, so predict and compare.
  always @(negedge clk) begin
    if (reset) begin
      q0.delete();
      q1.delete();
      exp_cnt0 = '0;
      exp_cnt1 = '0;
    end else begin
      room0  = (q0.size() < DEPTH) || (DEPTH == 1 && bus.out0_ready);
      room1  = (q1.size() < DEPTH) || (DEPTH == 1 && bus.out1_ready);
      exp_ir = !flush && (bus.in_sel ? room1 : room0);
      n_checks++;
      if (bus.in_ready !== exp_ir) begin
        n_fail++;
        $display("FAIL sb_in_ready t=%0t got %b want %b", $time, bus.in_ready, exp_ir);
      end
      n_checks++;
      if (bus.out0_valid !== (q0.size() != 0)) begin
        n_fail++;
        $display("FAIL sb_out0_valid t=%0t got %b want %b", $time, bus.out0_valid, q0.size() != 0);
      end
      n_checks++;
      if (bus.out1_valid !== (q1.size() != 0)) begin
        n_fail++;
        $display("FAIL sb_out1_valid t=%0t got %b want %b", $time, bus.out1_valid, q1.size() != 0);
      end
      n_checks++;
      if (cnt0 !== exp_cnt0 || cnt1 !== exp_cnt1) begin
        n_fail++;
        $display("FAIL sb_counters t=%0t got %h/%h want %h/%h", $time, cnt0, cnt1, exp_cnt0, exp_cnt1);
      end
      if (q0.size() != 0) begin
        n_checks++;
        if (bus.out0_data !== q0[0]) begin
          n_fail++;
          $display("FAIL sb_out0_data t=%0t got %h want %h", $time, bus.out0_data, q0[0]);
        end
        if (bus.out0_ready) begin
          void'(q0.pop_front());
          exp_cnt0 = exp_cnt0 + 16'd1;
        end
      end
      if (q1.size() != 0) begin
        n_checks++;
        if (bus.out1_data !== q1[0]) begin
          n_fail++;
          $display("FAIL sb_out1_data t=%0t got %h want %h", $time, bus.out1_data, q1[0]);
        end
        if (bus.out1_ready) begin
          void'(q1.pop_front());
          exp_cnt1 = exp_cnt1 + 16'd1;
        end
      end
      if (bus.in_valid && exp_ir) begin
        if (bus.in_sel) q1.push_back(bus.in_data);
        else            q0.push_back(bus.in_data);
      end
      if (flush) begin
        q0.delete();
        q1.delete();
      end
    end
  end

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [WIDTH-1:0] d, input logic s);
    bus.in_valid = v;
    bus.in_data  = d;
    bus.in_sel   = s;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    #1;
    n_checks++;
    if (bus.out0_valid !== 1'b0 || bus.out1_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_valid got %b%b want 00", bus.out1_valid, bus.out0_valid);
    end
    n_checks++;
    if (bus.out0_data !== 8'h00 || bus.out1_data !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_data got %h/%h want 00/00", bus.out0_data, bus.out1_data);
    end
    n_checks++;
    if (cnt0 !== 16'h0 || cnt1 !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_cnt got %h/%h want 0/0", cnt0, cnt1);
    end
    reset = 1'b0;
    step();
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready got %b want 1", bus.in_ready);
    end
  endtask

  task automatic test_steering();
    bus.out0_ready = 1'b1;
    bus.out1_ready = 1'b1;
    drive(1'b1, 8'h11, 1'b0);
    step();
    drive(1'b1, 8'h22, 1'b1);
    #1;
    n_checks++;
    if (bus.out0_valid !== 1'b1 || bus.out0_data !== 8'h11) begin
      n_fail++;
      $display("FAIL steer_out0_first got %b/%h want 1/11", bus.out0_valid, bus.out0_data);
    end
    step();
    drive(1'b1, 8'h33, 1'b0);
    #1;
    n_checks++;
    if (bus.out1_valid !== 1'b1 || bus.out1_data !== 8'h22 || bus.out0_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL steer_out1 got %b/%h out0_valid %b want 1/22 0", bus.out1_valid, bus.out1_data, bus.out0_valid);
    end
    step();
    drive(1'b0, 8'h00, 1'b0);
    #1;
    n_checks++;
    if (bus.out0_valid !== 1'b1 || bus.out0_data !== 8'h33) begin
      n_fail++;
      $display("FAIL steer_out0_second got %b/%h want 1/33", bus.out0_valid, bus.out0_data);
    end
    step();
    #1;
    n_checks++;
    if (cnt0 !== 16'd2 || cnt1 !== 16'd1) begin
      n_fail++;
      $display("FAIL steer_cnt got %0d/%0d want 2/1", cnt0, cnt1);
    end
  endtask

  task automatic test_backpressure();
    bus.out0_ready = 1'b0;
    bus.out1_ready = 1'b1;
    drive(1'b1, 8'hA0, 1'b0);
    step();
    drive(1'b1, 8'hA1, 1'b0);
    #1;
    n_checks++;
    if (bus.out0_data !== 8'hA0 || bus.in_ready !== 1'(DEPTH == 2)) begin
      n_fail++;
      $display("FAIL bp_a1_ready got %h/%b want A0/%b", bus.out0_data, bus.in_ready, DEPTH == 2);
    end
`ifdef DISPATCH_SKID_EN
    step();
    drive(1'b1, 8'hB0, 1'b1);
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1 || bus.out0_data !== 8'hA0) begin
      n_fail++;
      $display("FAIL bp_b0_ready got %b/%h want 1/A0", bus.in_ready, bus.out0_data);
    end
    step();
    drive(1'b1, 8'hC0, 1'b0);
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b0 || bus.out1_data !== 8'hB0) begin
      n_fail++;
      $display("FAIL bp_full_stall got %b/%h want 0/B0", bus.in_ready, bus.out1_data);
    end
    bus.out0_ready = 1'b1;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_no_ready_path got %b want 0", bus.in_ready);
    end
    step();
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1 || bus.out0_data !== 8'hA1) begin
      n_fail++;
      $display("FAIL bp_drain_a0 got %b/%h want 1/A1", bus.in_ready, bus.out0_data);
    end
    step();
    drive(1'b0, 8'h00, 1'b0);
    #1;
    n_checks++;
    if (bus.out0_valid !== 1'b1 || bus.out0_data !== 8'hC0) begin
      n_fail++;
      $display("FAIL bp_c0 got %b/%h want 1/C0", bus.out0_valid, bus.out0_data);
    end
    step();
`else
    step();
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b0 || bus.out0_data !== 8'hA0 || bus.out1_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_hol got %b/%h out1_valid %b want 0/A0 0", bus.in_ready, bus.out0_data, bus.out1_valid);
    end
    bus.out0_ready = 1'b1;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_ready_path got %b want 1", bus.in_ready);
    end
    step();
    drive(1'b1, 8'hB0, 1'b1);
    #1;
    n_checks++;
    if (bus.out0_data !== 8'hA1 || bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_a1 got %h/%b want A1/1", bus.out0_data, bus.in_ready);
    end
    step();
    drive(1'b0, 8'h00, 1'b0);
    #1;
    n_checks++;
    if (bus.out1_data !== 8'hB0 || bus.out0_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_b0 got %h out0_valid %b want B0 0", bus.out1_data, bus.out0_valid);
    end
`endif
    step();
    #1;
    n_checks++;
    if (cnt0 !== CNT0_BP || cnt1 !== 16'd2) begin
      n_fail++;
      $display("FAIL bp_cnt got %0d/%0d want %0d/2", cnt0, cnt1, CNT0_BP);
    end
  endtask

  task automatic test_replace();
    bus.out0_ready = 1'b0;
    bus.out1_ready = 1'b0;
    drive(1'b1, 8'h55, 1'b1);
    step();
    drive(1'b1, 8'h66, 1'b1);
    bus.out1_ready = 1'b1;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1 || bus.out1_data !== 8'h55) begin
      n_fail++;
      $display("FAIL rep_ready got %b/%h want 1/55", bus.in_ready, bus.out1_data);
    end
    step();
    drive(1'b0, 8'h00, 1'b0);
    #1;
    n_checks++;
    if (bus.out1_valid !== 1'b1 || bus.out1_data !== 8'h66 || cnt1 !== 16'd3) begin
      n_fail++;
      $display("FAIL rep_out1 got %b/%h cnt1 %0d want 1/66 3", bus.out1_valid, bus.out1_data, cnt1);
    end
    step();
    #1;
    n_checks++;
    if (bus.out1_valid !== 1'b0 || cnt1 !== 16'd4) begin
      n_fail++;
      $display("FAIL rep_drain got %b cnt1 %0d want 0 4", bus.out1_valid, cnt1);
    end
  endtask

  task automatic test_flush();
    bus.out0_ready = 1'b0;
    bus.out1_ready = 1'b0;
    drive(1'b1, 8'hE0, 1'b0);
    step();
    drive(1'b1, 8'hE1, 1'b1);
    step();
    drive(1'b1, 8'hF0, 1'b0);
    bus.out0_ready = 1'b1;
    flush = 1'b1;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b0 || bus.out0_valid !== 1'b1 || bus.out1_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_cycle got ready %b valids %b%b want 0 11", bus.in_ready, bus.out1_valid, bus.out0_valid);
    end
    step();
    flush = 1'b0;
    drive(1'b0, 8'h00, 1'b0);
    bus.out0_ready = 1'b0;
    #1;
    n_checks++;
    if (bus.out0_valid !== 1'b0 || bus.out1_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_empty got %b%b want 00", bus.out1_valid, bus.out0_valid);
    end
    n_checks++;
    if (cnt0 !== CNT0_BP + 16'd1 || cnt1 !== 16'd4) begin
      n_fail++;
      $display("FAIL flush_cnt got %0d/%0d want %0d/4", cnt0, cnt1, CNT0_BP + 16'd1);
    end
    step();
  endtask

  task automatic test_counter_wrap();
    reset = 1'b1;
    step();
    reset = 1'b0;
    bus.out0_ready = 1'b1;
    bus.out1_ready = 1'b0;
    for (int i = 0; i < 65535; i++) begin
      drive(1'b1, WIDTH'(i), 1'b0);
      step();
    end
    drive(1'b0, 8'h00, 1'b0);
    step();
    #1;
    n_checks++;
    if (cnt0 !== 16'hFFFF || cnt1 !== 16'h0000) begin
      n_fail++;
      $display("FAIL wrap_preload got %h/%h want FFFF/0000", cnt0, cnt1);
    end
    drive(1'b1, 8'h5A, 1'b0);
    step();
    drive(1'b0, 8'h00, 1'b0);
    step();
    #1;
    n_checks++;
    if (cnt0 !== 16'h0000 || cnt1 !== 16'h0000 || bus.out0_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_cnt got %h/%h valid %b want 0000/0000 0", cnt0, cnt1, bus.out0_valid);
    end
  endtask

  // Guard against a stuck run.
  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset          = 1'b1;
    flush          = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus.in_sel     = 1'b0;
    bus.out0_ready = 1'b0;
    bus.out1_ready = 1'b0;
    test_reset();
    test_steering();
    test_backpressure();
    test_replace();
    test_flush();
    test_counter_wrap();
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
